// File: rtl/uart_rx_ctrl.sv
// UART receive controller: OFF/RUN/STALL flow control in front of a first-word-fall-through
// byte FIFO, with sticky overflow/error flags. Define UART_RX_ERR_CNT_EN to add err_count.
module uart_rx_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ctrl_en,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_stop_error,
  input  logic       rx_parity_error,
  output logic       rx_en,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       ovf_flag,
  output logic       err_flag,
  input  logic       flag_clr
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RUN,
    ST_STALL
  } state_e;

  state_e        state_q;
  logic          rx_en_q;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_q;
  logic          err_q;

  logic full;
  logic pop;
  logic push;
  logic frame_err;
  logic frame_live;
  logic drop_err;
  logic drop_ovf;

  // Frame classification: OFF ignores everything, errors beat overflow.
  assign full       = (count_q == CW'(DEPTH));
  assign pop        = m_valid & m_ready;
  assign frame_err  = rx_stop_error | rx_parity_error;
  assign frame_live = rx_valid && (state_q != ST_OFF);
  assign drop_err   = frame_live && frame_err;
  assign drop_ovf   = frame_live && !frame_err && ((state_q == ST_STALL) || (full && !pop));
  assign push       = frame_live && !frame_err && (state_q == ST_RUN) && (!full || pop);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Transitions look at the post-update occupancy; ctrl_en low forces OFF from any state.
  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_OFF;
      rx_en_q <= 1'b0;
    end else if (!ctrl_en) begin
      state_q <= ST_OFF;
      rx_en_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          state_q <= ST_RUN;
          rx_en_q <= 1'b1;
        end
        ST_RUN: begin
          if (count_d == CW'(DEPTH)) begin
            state_q <= ST_STALL;
            rx_en_q <= 1'b0;
          end
        end
        ST_STALL: begin
          if (count_d <= CW'(DEPTH - 2)) begin
            state_q <= ST_RUN;
            rx_en_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_OFF;
          rx_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  // Sticky flags: a set in the same cycle as flag_clr wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (drop_ovf)      ovf_q <= 1'b1;
      else if (flag_clr) ovf_q <= 1'b0;
      if (drop_err)      err_q <= 1'b1;
      else if (flag_clr) err_q <= 1'b0;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= 8'h00;
    end else if (drop_err) begin
      if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'h01;
    end else if (flag_clr) begin
      err_count_q <= 8'h00;
    end
  end

  assign err_count = err_count_q;
`endif

  assign rx_en    = rx_en_q;
  assign m_valid  = (count_q != '0);
  assign m_data   = m_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign ovf_flag = ovf_q;
  assign err_flag = err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-based reference model updated on each rising edge, a negedge
// monitor comparing DUT outputs and popped bytes against it, directed scenarios then random traffic.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       ctrl_en;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_stop_error;
  logic       rx_parity_error;
  logic       rx_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       ovf_flag;
  logic       err_flag;
  logic       flag_clr;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .ctrl_en         (ctrl_en),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rx_stop_error   (rx_stop_error),
    .rx_parity_error (rx_parity_error),
    .rx_en           (rx_en),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .ovf_flag        (ovf_flag),
    .err_flag        (err_flag),
    .flag_clr        (flag_clr)
`ifdef UART_RX_ERR_CNT_EN
    ,
    .err_count       (err_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy, receive mode and flags; accepted bytes go to exp_q.
  typedef enum {MODE_OFF, MODE_RUN, MODE_STALL} mode_e;

  mode_e      mdl_mode = MODE_OFF;
  int         mdl_occ  = 0;
  bit         mdl_ovf  = 1'b0;
  bit         mdl_err  = 1'b0;
  int         mdl_ecnt = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) begin : model
    bit do_pop;
    bit do_push;
    bit bad_frame;
    bit good_drop;
    if (reset) begin
      mdl_mode = MODE_OFF;
      mdl_occ  = 0;
      mdl_ovf  = 1'b0;
      mdl_err  = 1'b0;
      mdl_ecnt = 0;
      exp_q.delete();
    end else begin
      do_pop    = (mdl_occ > 0) && m_ready;
      do_push   = 1'b0;
      bad_frame = 1'b0;
      good_drop = 1'b0;
      if (rx_valid && mdl_mode != MODE_OFF) begin
        if (rx_stop_error || rx_parity_error) bad_frame = 1'b1;
        else if (mdl_mode == MODE_STALL || (mdl_occ == DEPTH && !do_pop)) good_drop = 1'b1;
        else do_push = 1'b1;
      end
      if (do_pop)  mdl_occ--;
      if (do_push) begin
        mdl_occ++;
        exp_q.push_back(rx_data);
      end
      if (good_drop)     mdl_ovf = 1'b1;
      else if (flag_clr) mdl_ovf = 1'b0;
      if (bad_frame)     mdl_err = 1'b1;
      else if (flag_clr) mdl_err = 1'b0;
      if (bad_frame)     mdl_ecnt = (mdl_ecnt < 255) ? mdl_ecnt + 1 : 255;
      else if (flag_clr) mdl_ecnt = 0;
      if (!ctrl_en)                                        mdl_mode = MODE_OFF;
      else if (mdl_mode == MODE_OFF)                       mdl_mode = MODE_RUN;
      else if (mdl_mode == MODE_RUN && mdl_occ == DEPTH)   mdl_mode = MODE_STALL;
      else if (mdl_mode == MODE_STALL && mdl_occ <= DEPTH - 2) mdl_mode = MODE_RUN;
    end
  end

  // Monitor: mid-cycle comparison of DUT outputs against the model and the byte scoreboard.
  always @(negedge clk) begin
    check("m_valid", m_valid, (mdl_occ != 0));
    check("rx_en", rx_en, (mdl_mode == MODE_RUN));
    check("ovf_flag", ovf_flag, mdl_ovf);
    check("err_flag", err_flag, mdl_err);
`ifdef UART_RX_ERR_CNT_EN
    check("err_count", err_count, mdl_ecnt);
`endif
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underrun: m_valid=1 m_data=0x%0h but no byte expected at %0t",
                 m_data, $time);
      end else begin
        check("m_data", m_data, exp_q[0]);
        if (m_ready && !reset) void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic pe = 1'b0, input logic se = 1'b0);
    rx_valid        = 1'b1;
    rx_data         = d;
    rx_parity_error = pe;
    rx_stop_error   = se;
    cyc();
    rx_valid        = 1'b0;
    rx_parity_error = 1'b0;
    rx_stop_error   = 1'b0;
  endtask

  task automatic pulse_clr();
    flag_clr = 1'b1;
    cyc();
    flag_clr = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    ctrl_en         = 1'b0;
    rx_valid        = 1'b0;
    rx_data         = 8'h00;
    rx_stop_error   = 1'b0;
    rx_parity_error = 1'b0;
    m_ready         = 1'b0;
    flag_clr        = 1'b0;
    cyc();

    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_rx_en", rx_en, 1'b0);
    check("rst_flags", {ovf_flag, err_flag}, 2'b00);

    // Enable, single byte with a ready consumer.
    reset   = 1'b0;
    ctrl_en = 1'b1;
    m_ready = 1'b1;
    cyc();
    check("en_rx_en", rx_en, 1'b1);
    send(8'hA5);
    check("a5_valid", m_valid, 1'b1);
    check("a5_data", m_data, 8'hA5);
    cyc();
    check("a5_gone", m_valid, 1'b0);

    // Fill to DEPTH, stall, overflow drop, resume after two pops.
    m_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) send(8'(i));
    check("stall_rx_en", rx_en, 1'b0);
    send(8'h05);
    check("stall_ovf", ovf_flag, 1'b1);
    m_ready = 1'b1;
    cyc();
    check("stall_hold", rx_en, 1'b0);
    cyc();
    m_ready = 1'b0;
    check("resume_rx_en", rx_en, 1'b1);
    m_ready = 1'b1;
    repeat (2) cyc();
    m_ready = 1'b0;
    check("drain_empty", m_valid, 1'b0);
    pulse_clr();
    check("ovf_cleared", ovf_flag, 1'b0);

    // Errored frames are dropped and flagged.
    send(8'h3C, 1'b1, 1'b0);
    send(8'h3D, 1'b0, 1'b1);
    check("err_set", err_flag, 1'b1);
    check("err_no_push", m_valid, 1'b0);
`ifdef UART_RX_ERR_CNT_EN
    check("err_cnt2", err_count, 8'd2);
`endif
    pulse_clr();
    check("err_cleared", err_flag, 1'b0);
`ifdef UART_RX_ERR_CNT_EN
    check("err_cnt0", err_count, 8'd0);
`endif

    // Full FIFO while in RUN: simultaneous push and pop is accepted.
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    ctrl_en = 1'b0;
    cyc();
    ctrl_en = 1'b1;
    cyc();
    check("full_run_rx_en", rx_en, 1'b1);
    m_ready = 1'b1;
    send(8'h77);
    m_ready = 1'b0;
    check("full_swap_ovf", ovf_flag, 1'b0);
    check("full_swap_valid", m_valid, 1'b1);
    m_ready = 1'b1;
    repeat (DEPTH) cyc();
    m_ready = 1'b0;
    check("full_swap_drained", m_valid, 1'b0);

    // Reset with three held entries and ovf set, with a frame in flight.
    for (int i = 0; i <= DEPTH; i++) send(8'h51 + 8'(i));
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    check("pre_rst_ovf", ovf_flag, 1'b1);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hEE;
    cyc();
    rx_valid = 1'b0;
    check("rst2_m_valid", m_valid, 1'b0);
    check("rst2_m_data", m_data, 8'h00);
    check("rst2_flags", {ovf_flag, err_flag}, 2'b00);
    check("rst2_rx_en", rx_en, 1'b0);
    reset = 1'b0;
    cyc();

    // Disable with two held entries: frames ignored, contents still drain.
    send(8'h61);
    send(8'h62);
    ctrl_en = 1'b0;
    cyc();
    check("off_rx_en", rx_en, 1'b0);
    send(8'h99);
    send(8'h9A, 1'b1, 1'b0);
    check("off_no_flags", {ovf_flag, err_flag}, 2'b00);
    check("off_retained", m_valid, 1'b1);
    m_ready = 1'b1;
    repeat (2) cyc();
    m_ready = 1'b0;
    check("off_drained", m_valid, 1'b0);
    ctrl_en = 1'b1;
    cyc();

    // Randomized traffic; the monitor does the checking.
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) < 3) ctrl_en = ~ctrl_en;
      rx_valid        = ($urandom_range(0, 99) < 45);
      rx_data         = 8'($urandom);
      rx_parity_error = ($urandom_range(0, 99) < 8);
      rx_stop_error   = ($urandom_range(0, 99) < 8);
      m_ready         = ($urandom_range(0, 99) < 40);
      flag_clr        = ($urandom_range(0, 99) < 4);
      cyc();
    end

    reset           = 1'b0;
    rx_valid        = 1'b0;
    rx_parity_error = 1'b0;
    rx_stop_error   = 1'b0;
    flag_clr        = 1'b0;
    m_ready         = 1'b1;
    repeat (2 * DEPTH) cyc();
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
